rr_l2_arbiter: RTL and testbench

RR_L2_ARBITER -- requirements
Module: rr_l2_arbiter

---
 rtl/rr_l2_arbiter.sv | 137 +++++++++++++
 tb/tb_rr_l2_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_l2_arbiter.sv
// Two-requester round-robin arbiter in front of a line-oriented L2 port.
// One access is in flight at a time; a stalled L2 is aborted after TIMEOUT BUSY cycles.
module rr_l2_arbiter #(
    parameter int N            = 32,
    parameter int BLOCKSIZE    = 8,
    parameter int WORDSIZE     = 4,
    parameter int WORDSPERLINE = BLOCKSIZE / WORDSIZE,
    parameter int TIMEOUT      = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_1,
    input  logic                              req_2,
    input  logic                              we_1,
    input  logic                              we_2,
    input  logic [N-1:0]                      addr_1,
    input  logic [N-1:0]                      addr_2,
    input  logic [WORDSPERLINE-1:0][N-1:0]    wdata_1,
    input  logic [WORDSPERLINE-1:0][N-1:0]    wdata_2,
    output logic                              ready_1,
    output logic                              ready_2,
    output logic [WORDSPERLINE-1:0][N-1:0]    rdata_1,
    output logic [WORDSPERLINE-1:0][N-1:0]    rdata_2,
    output logic                              hit_1,
    output logic                              hit_2,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [N-1:0]                      mem_addr,
    output logic [WORDSPERLINE-1:0][N-1:0]    mem_wdata,
    input  logic                              mem_done,
    input  logic [WORDSPERLINE-1:0][N-1:0]    mem_rdata,
    input  logic                              mem_hit,
    output logic                              err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       ptr;        // 0 = requester 1 preferred, 1 = requester 2 preferred
    logic       grant;      // requester owning the access in flight
    logic       sel;
    logic [7:0] cnt;
    logic       start;
    logic       done_ok;
    logic       done_to;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_next = state;
        start      = 1'b0;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        sel        = (req_1 && req_2) ? ptr : req_2;
        case (state)
            IDLE: if (req_1 || req_2) begin
                start      = 1'b1;
                state_next = BUSY;
            end
            BUSY: if (mem_done) begin
                done_ok    = 1'b1;
                state_next = RESP;
            end else if (cnt == CNT_LAST) begin
                done_to    = 1'b1;
                state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 1'b0;
            grant     <= 1'b0;
            cnt       <= '0;
            err       <= 1'b0;
            ready_1   <= 1'b0;
            ready_2   <= 1'b0;
            rdata_1   <= '0;
            rdata_2   <= '0;
            hit_1     <= 1'b0;
            hit_2     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            ready_1 <= 1'b0;
            ready_2 <= 1'b0;
            rdata_1 <= '0;
            rdata_2 <= '0;
            hit_1   <= 1'b0;
            hit_2   <= 1'b0;
            if (start) begin
                grant     <= sel;
                cnt       <= '0;
                mem_req   <= 1'b1;
                mem_we    <= sel ? we_2    : we_1;
                mem_addr  <= sel ? addr_2  : addr_1;
                mem_wdata <= sel ? wdata_2 : wdata_1;
            end else if (done_ok || done_to) begin
                // A timed-out access still completes towards the requester, with zeroed data.
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
                ptr       <= ~grant;
                err       <= err | done_to;
                if (grant) begin
                    ready_2 <= 1'b1;
                    rdata_2 <= done_ok ? mem_rdata : '0;
                    hit_2   <= done_ok & mem_hit;
                end else begin
                    ready_1 <= 1'b1;
                    rdata_1 <= done_ok ? mem_rdata : '0;
                    hit_1   <= done_ok & mem_hit;
                end
            end else if (state == BUSY) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rr_l2_arbiter.sv
// Directed scoreboard bench for rr_l2_arbiter, built with TIMEOUT = 4.
// Expected completions are queued when a request is driven and compared on each ready pulse.
module tb_rr_l2_arbiter;

    localparam int N  = 32;
    localparam int WL = 2;

    typedef struct {
        int          who;
        logic [63:0] rdata;
        logic        hit;
        logic        err;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_1, req_2, we_1, we_2;
    logic [N-1:0]         addr_1, addr_2;
    logic [WL-1:0][N-1:0] wdata_1, wdata_2;
    logic                 ready_1, ready_2;
    logic [WL-1:0][N-1:0] rdata_1, rdata_2;
    logic                 hit_1, hit_2;
    logic                 mem_req, mem_we;
    logic [N-1:0]         mem_addr;
    logic [WL-1:0][N-1:0] mem_wdata;
    logic                 mem_done;
    logic [WL-1:0][N-1:0] mem_rdata;
    logic                 mem_hit;
    logic                 err;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    rr_l2_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_1(req_1), .req_2(req_2), .we_1(we_1), .we_2(we_2),
        .addr_1(addr_1), .addr_2(addr_2), .wdata_1(wdata_1), .wdata_2(wdata_2),
        .ready_1(ready_1), .ready_2(ready_2), .rdata_1(rdata_1), .rdata_2(rdata_2),
        .hit_1(hit_1), .hit_2(hit_2),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_hit(mem_hit),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail(input string tag);
        n_checks++;
        n_errors++;
        $error("FAIL %s: observed=timeout expected=event", tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {53'd0, ready_1, ready_2, hit_1, hit_2, mem_req, mem_we, err,
                    |rdata_1, |rdata_2, |mem_addr, |mem_wdata}, 64'd0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        req_1 = 1'b0; req_2 = 1'b0; we_1 = 1'b0; we_2 = 1'b0;
        addr_1 = '0; addr_2 = '0; wdata_1 = '0; wdata_2 = '0;
        mem_done = 1'b0; mem_rdata = '0; mem_hit = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Plays the L2: checks the request on every BUSY cycle, pulses mem_done on BUSY cycle 'delay'.
    task automatic l2_serve(input int delay, input logic [63:0] data, input logic hit,
                            input logic [31:0] e_addr, input logic e_we, input logic [63:0] e_wdata);
        int n;
        n = 0;
        @(negedge clk);
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req) begin
            fail("mem_req_wait");
            return;
        end
        for (int i = 0; i <= delay; i++) begin
            check("busy_mem_req", 64'(mem_req), 64'd1);
            check("busy_mem_addr", 64'(mem_addr), 64'(e_addr));
            check("busy_mem_we", 64'(mem_we), 64'(e_we));
            check("busy_mem_wdata", mem_wdata, e_wdata);
            if (i == delay) begin
                mem_done  = 1'b1;
                mem_rdata = data;
                mem_hit   = hit;
            end
            step();
            if (i < delay) @(negedge clk);
        end
        mem_done  = 1'b0;
        mem_rdata = '0;
        mem_hit   = 1'b0;
    endtask

    // Waits for a ready pulse (bounded), pops the scoreboard and compares.
    task automatic check_resp(input int exp_cycles);
        exp_t        e;
        int          who;
        int          cycles;
        logic [63:0] rd, od;
        logic        h, oh;
        who = 0;
        cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ready_1 || ready_2) begin
                who = ready_1 ? 1 : 2;
                cycles = i;
                break;
            end
        end
        if (sb.size() == 0) begin
            fail("scoreboard_empty");
            return;
        end
        e = sb.pop_front();
        if (who == 0) begin
            fail("ready_wait");
            return;
        end
        rd = (who == 1) ? rdata_1 : rdata_2;
        od = (who == 1) ? rdata_2 : rdata_1;
        h  = (who == 1) ? hit_1 : hit_2;
        oh = (who == 1) ? hit_2 : hit_1;
        check("grant_who", 64'(who), 64'(e.who));
        check("ready_latency", 64'(cycles), 64'(exp_cycles));
        check("resp_rdata", rd, e.rdata);
        check("resp_hit", 64'(h), 64'(e.hit));
        check("other_rdata_zero", od, 64'd0);
        check("other_hit_zero", 64'(oh), 64'd0);
        check("resp_err", 64'(err), 64'(e.err));
        check("resp_mem_req", 64'(mem_req), 64'd0);
        @(negedge clk);
        check("ready_one_cycle", {62'd0, ready_1, ready_2}, 64'd0);
        check("rdata_cleared", 64'(rdata_1 | rdata_2), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) check("ready_overlap", 64'(ready_1 & ready_2), 64'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] d;
        int          who;

        // Reset state
        reset_dut();
        @(negedge clk);
        check_all_zero("reset_outputs");

        // Stray mem_done in IDLE is ignored
        step();
        mem_done = 1'b1; mem_hit = 1'b1; mem_rdata = '1;
        @(negedge clk);
        check_all_zero("stray_done_same_cycle");
        step();
        mem_done = 1'b0; mem_hit = 1'b0; mem_rdata = '0;
        repeat (2) begin
            @(negedge clk);
            check_all_zero("stray_done_after");
        end

        // Single read from requester 1, L2 hit after 2 cycles
        step();
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 32'h100;
        sb.push_back('{1, 64'h1111_2222_3333_4444, 1'b1, 1'b0});
        step();
        req_1 = 1'b0;
        l2_serve(2, 64'h1111_2222_3333_4444, 1'b1, 32'h100, 1'b0, 64'd0);
        check_resp(1);

        // ptr now points at requester 2: contention grants 2; inputs changed during BUSY are ignored
        step();
        req_1 = 1'b1; addr_1 = 32'h200;
        req_2 = 1'b1; we_2 = 1'b1; addr_2 = 32'h300; wdata_2 = 64'hAAAA5555_12345678;
        sb.push_back('{2, 64'h5A5A_0000_0000_0001, 1'b0, 1'b0});
        step();
        req_1 = 1'b0; req_2 = 1'b0; addr_2 = 32'hFFFF; wdata_2 = '1; we_2 = 1'b0;
        l2_serve(2, 64'h5A5A_0000_0000_0001, 1'b0, 32'h300, 1'b1, 64'hAAAA5555_12345678);
        check_resp(1);

        // Lone requester 2 is granted even though ptr now favours requester 1
        step();
        req_2 = 1'b1; we_2 = 1'b1; addr_2 = 32'h340; wdata_2 = 64'h0F0F_F0F0_DEAD_BEEF;
        sb.push_back('{2, 64'h0, 1'b1, 1'b0});
        step();
        req_2 = 1'b0;
        l2_serve(1, 64'h0, 1'b1, 32'h340, 1'b1, 64'h0F0F_F0F0_DEAD_BEEF);
        check_resp(1);

        // Both requesters held high from reset: grants 1, 2, 1, 2
        reset_dut();
        step();
        req_1 = 1'b1; addr_1 = 32'h1000; we_1 = 1'b0;
        req_2 = 1'b1; addr_2 = 32'h2000; we_2 = 1'b0; wdata_2 = '0;
        for (int t = 0; t < 4; t++) begin
            who = (t % 2 == 0) ? 1 : 2;
            d   = 64'hC0DE_0000_0000_0000 + 64'(t * 17 + 1);
            sb.push_back('{who, d, t[0], 1'b0});
            l2_serve(1 + t % 2, d, t[0], (who == 1) ? 32'h1000 : 32'h2000, 1'b0, 64'd0);
            if (t == 3) begin
                req_1 = 1'b0;
                req_2 = 1'b0;
            end
            check_resp(1);
        end

        // mem_done on the last allowed BUSY cycle wins over the timeout
        step();
        req_1 = 1'b1; addr_1 = 32'h480;
        sb.push_back('{1, 64'h7777_8888_9999_AAAA, 1'b1, 1'b0});
        step();
        req_1 = 1'b0;
        l2_serve(3, 64'h7777_8888_9999_AAAA, 1'b1, 32'h480, 1'b0, 64'd0);
        check_resp(1);

        // mem_done withheld: abort after 4 BUSY cycles with zeroed data, sticky err
        step();
        req_1 = 1'b1; addr_1 = 32'h500;
        mem_rdata = '1; mem_hit = 1'b1;
        sb.push_back('{1, 64'd0, 1'b0, 1'b1});
        step();
        req_1 = 1'b0;
        check_resp(5);
        mem_rdata = '0; mem_hit = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("err_sticky", 64'(err), 64'd1);
        end

        // Normal access afterwards keeps err set; ptr moved to 2 so lone req_1 still wins
        step();
        req_1 = 1'b1; addr_1 = 32'h520;
        sb.push_back('{1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1});
        step();
        req_1 = 1'b0;
        l2_serve(0, 64'h0123_4567_89AB_CDEF, 1'b0, 32'h520, 1'b0, 64'd0);
        check_resp(1);

        // Reset in the 2nd BUSY cycle, then a late mem_done
        step();
        req_1 = 1'b1; addr_1 = 32'h440;
        step();
        req_1 = 1'b0;
        @(negedge clk);
        check("abort_busy_mem_req", 64'(mem_req), 64'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort_mem_req_dropped", 64'(mem_req), 64'd0);
        check("abort_err_cleared", 64'(err), 64'd0);
        mem_done = 1'b1; mem_hit = 1'b1; mem_rdata = '1;
        step();
        mem_done = 1'b0; mem_hit = 1'b0; mem_rdata = '0;
        repeat (4) begin
            @(negedge clk);
            check_all_zero("abort_no_ready");
        end

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
